imm_encoder: RTL and testbench

- Inverse of the immediate extend unit: packs a signed 32-bit immediate into the I/S/B/J bit positions of a 32-bit RV32I instruction word.
- Used by the self-test program generator and boot-ROM loader to build instruction words in hardware.
- Two-stage valid/ready pipeline: stage 1 range-checks, stage 2 packs.
- Round-trip contract: for any error-free output, the extend unit given `instr[31:7]` and the same `control` returns `imm` exactly.

---
 rtl/imm_encoder_pkg.sv | 76 +++++++
 rtl/imm_encoder_range_check.sv | 30 +++
 rtl/imm_encoder.sv | 155 +++++++++++++++
 tb/tb_imm_encoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions for the RV32I extend unit and the
// immediate encoder: format codes, legal ranges and the stage-2 packer.
package imm_encoder_pkg;

    // Same two-bit code the extend unit decodes.
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_fmt_e;

    // Representable immediate ranges (inclusive). B/J must also be even.
    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_S_MIN = -2048;
    localparam int IMM_S_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    // Widest format (J) only needs imm[20:0]; upper bits are sign copies.
    localparam int unsigned IMM_KEEP_W = 21;

    // Instruction bit positions owned by each format's immediate.
    function automatic logic [31:0] imm_field_mask(input imm_fmt_e fmt);
        logic [31:0] mask;
        case (fmt)
            IMM_I:   mask = 32'hFFF0_0000;
            IMM_S:   mask = 32'hFE00_0F80;
            IMM_B:   mask = 32'hFE00_0F80;
            IMM_J:   mask = 32'hFFFF_F000;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

    // Scatter the immediate into its instruction fields; other bits come from
    // base. With err set the immediate fields are left zero.
    function automatic logic [31:0] pack_imm(
        input logic [31:0]           base,
        input logic [IMM_KEEP_W-1:0] imm,
        input imm_fmt_e              fmt,
        input logic                  err
    );
        logic [31:0] word;
        word = base & ~imm_field_mask(fmt);
        if (!err) begin
            case (fmt)
                IMM_I: begin
                    word[31:20] = imm[11:0];
                end
                IMM_S: begin
                    word[31:25] = imm[11:5];
                    word[11:7]  = imm[4:0];
                end
                IMM_B: begin
                    word[31]    = imm[12];
                    word[30:25] = imm[10:5];
                    word[11:8]  = imm[4:1];
                    word[7]     = imm[11];
                end
                IMM_J: begin
                    word[31]    = imm[20];
                    word[30:21] = imm[10:1];
                    word[20]    = imm[11];
                    word[19:12] = imm[19:12];
                end
                default: ;
            endcase
        end
        return word;
    endfunction

endpackage

// File: rtl/imm_encoder_range_check.sv
// Combinational range/alignment check of a signed immediate against the
// chosen RV32I format. Only built when IMM_ENCODER_RANGE_CHECK_EN is
// defined, since it is instantiated nowhere else.
`ifdef IMM_ENCODER_RANGE_CHECK_EN
module imm_range_check
    import imm_encoder_pkg::*;
(
    input  logic [31:0] imm,
    input  imm_fmt_e    fmt,
    output logic        err
);

    logic signed [31:0] simm;

    assign simm = $signed(imm);

    // Flag values outside the format range, and odd offsets for branch/jump.
    always_comb begin
        err = 1'b0;
        case (fmt)
            IMM_I:   err = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
            IMM_S:   err = (simm < IMM_S_MIN) || (simm > IMM_S_MAX);
            IMM_B:   err = (simm < IMM_B_MIN) || (simm > IMM_B_MAX) || imm[0];
            IMM_J:   err = (simm < IMM_J_MIN) || (simm > IMM_J_MAX) || imm[0];
            default: err = 1'b0;
        endcase
    end

endmodule
`endif

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a signed 32-bit immediate into the I/S/B/J fields
// of an RV32I instruction word. Two-stage valid/ready pipeline; stage 1
// registers the request (and its range check), stage 2 registers the packed
// word. Optional macro IMM_ENCODER_RANGE_CHECK_EN enables range/alignment
// checking and out_err; without it immediates are truncated into their fields.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_imm,
    input  logic [1:0]       in_control,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count
);

    imm_fmt_e in_fmt;

    logic                  s1_valid_q, s1_valid_d;
    logic [IMM_KEEP_W-1:0] s1_imm_q, s1_imm_d;
    imm_fmt_e              s1_fmt_q, s1_fmt_d;
    logic [31:0]           s1_base_q, s1_base_d;
    logic                  s1_err;

    logic                  s2_valid_q, s2_valid_d;
    logic [31:0]           s2_instr_q, s2_instr_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  s1_adv, s2_adv, in_xfer, out_xfer;

    assign in_fmt = imm_fmt_e'(in_control);

    // Handshake: a stage may load when empty or when its content moves on.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_valid_q && out_ready;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    logic in_err;
    logic s1_err_q, s1_err_d;
    logic s2_err_q, s2_err_d;

    imm_range_check u_range_check (
        .imm (in_imm),
        .fmt (in_fmt),
        .err (in_err)
    );

    assign s1_err  = s1_err_q;
    assign out_err = s2_err_q;

    // Error flag travels alongside the request through both stages.
    always_comb begin
        s1_err_d = s1_err_q;
        s2_err_d = s2_err_q;
        if (in_xfer) begin
            s1_err_d = in_err;
        end
        if (s2_adv && s1_valid_q) begin
            s2_err_d = s1_err_q;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err_q <= 1'b0;
            s2_err_q <= 1'b0;
        end else begin
            s1_err_q <= s1_err_d;
            s2_err_q <= s2_err_d;
        end
    end
`else
    // Upper immediate bits are pure sign copies and are dropped unchecked.
    logic unused_imm_hi;

    assign unused_imm_hi = ^in_imm[31:IMM_KEEP_W];
    assign s1_err        = 1'b0;
    assign out_err       = 1'b0;
`endif

    // Stage 1 next state: capture the request on accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_fmt_d   = s1_fmt_q;
        s1_base_d  = s1_base_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (in_xfer) begin
            s1_imm_d  = in_imm[IMM_KEEP_W-1:0];
            s1_fmt_d  = in_fmt;
            s1_base_d = in_base;
        end
    end

    // Stage 2 next state: pack the word; hold it while the consumer stalls.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = pack_imm(s1_base_q, s1_imm_q, s1_fmt_q, s1_err);
            end
        end
    end

    // Delivered-word counter, sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Pipeline and counter registers; reset discards in-flight requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_fmt_q   <= IMM_I;
            s1_base_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_fmt_q   <= s1_fmt_d;
            s1_base_q  <= s1_base_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign enc_count = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder. Runs in either build; the
// out-of-range vectors expect err words with the range-check macro and
// silently truncated words without it.
module tb_imm_encoder;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [1:0] F_I = 2'b00;
    localparam logic [1:0] F_S = 2'b01;
    localparam logic [1:0] F_B = 2'b10;
    localparam logic [1:0] F_J = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_imm = '0;
    logic [1:0]       in_control = '0;
    logic [31:0]      in_base = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned exp_cnt = 0;

    // Request queue for one run.
    logic [1:0]  q_ctl  [8];
    logic [31:0] q_base [8];
    logic [31:0] q_imm  [8];
    logic [31:0] q_exp  [8];
    logic        q_err  [8];
    logic        q_rt   [8];
    int          q_n = 0;

    always #5 clk = ~clk;

    imm_encoder #(
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_imm     (in_imm),
        .in_control (in_control),
        .in_base    (in_base),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .enc_count  (enc_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference extend unit: recovers the immediate from an instruction word.
    function automatic logic [31:0] ext_imm(input logic [31:0] i, input logic [1:0] c);
        case (c)
            F_I:     return {{20{i[31]}}, i[31:20]};
            F_S:     return {{20{i[31]}}, i[31:25], i[11:7]};
            F_B:     return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    task automatic push(input logic [1:0] c, input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] exp, input logic err, input logic rt);
        q_ctl[q_n]  = c;
        q_base[q_n] = base;
        q_imm[q_n]  = imm;
        q_exp[q_n]  = exp;
        q_err[q_n]  = err;
        q_rt[q_n]   = rt;
        q_n++;
    endtask

    // Stream the queued requests; out_ready is held low for the first `stall` cycles.
    task automatic run_seq(input string tag, input int stall);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int acc0 = -1;
        int ov0 = -1;
        int last = -1;
        while (got < q_n && cyc < 60) begin
            @(posedge clk);
            #1;
            in_valid = (sent < q_n);
            if (sent < q_n) begin
                in_control = q_ctl[sent];
                in_base    = q_base[sent];
                in_imm     = q_imm[sent];
            end
            out_ready = (cyc >= stall);
            #1;
            if (stall > 0 && cyc == 2) begin
                check_val({tag, " in_ready_full"}, {31'b0, in_ready}, 32'd0);
                check_val({tag, " accepted_before_full"}, sent, 32'd2);
            end
            if (out_valid && ov0 < 0) ov0 = cyc;
            if (out_valid && !out_ready) begin
                check_val($sformatf("%s hold%0d", tag, got), out_instr, q_exp[got]);
            end
            if (out_valid && out_ready) begin
                check_val($sformatf("%s instr%0d", tag, got), out_instr, q_exp[got]);
                check_val($sformatf("%s err%0d", tag, got), {31'b0, out_err}, {31'b0, q_err[got]});
                if (q_rt[got] && !q_err[got]) begin
                    check_val($sformatf("%s roundtrip%0d", tag, got),
                              ext_imm(out_instr, q_ctl[got]), q_imm[got]);
                end
                if (exp_cnt < CNT_MAX) exp_cnt++;
                last = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                if (sent == 0) acc0 = cyc;
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check_val({tag, " words"}, got, q_n);
        check_val({tag, " latency"}, ov0 - acc0, 32'd2);
        if (stall == 0) check_val({tag, " throughput"}, last, q_n + 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check_val({tag, " enc_count"}, {28'b0, enc_count}, exp_cnt);
        q_n = 0;
    endtask

    initial begin
        int stale;

        // Reset state while rst_n is held low.
        #12;
        check_val("rst out_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst out_instr", out_instr, 32'd0);
        check_val("rst out_err", {31'b0, out_err}, 32'd0);
        check_val("rst enc_count", {28'b0, enc_count}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("in_ready after reset", {31'b0, in_ready}, 32'd1);

        push(F_I, 32'h0000_0093, 32'd6, 32'h0060_0093, 1'b0, 1'b1);
        run_seq("i_pos", 0);
        push(F_I, 32'h0000_0093, -32'sd6, 32'hFFA0_0093, 1'b0, 1'b1);
        run_seq("i_neg", 0);
        push(F_S, 32'h0020_A023, -32'sd6, 32'hFE20_AD23, 1'b0, 1'b1);
        run_seq("s_neg", 0);
        push(F_S, 32'h0020_A023, 32'd6, 32'h0020_A323, 1'b0, 1'b1);
        run_seq("s_pos", 0);
        push(F_B, 32'h0020_8063, -32'sd4, 32'hFE20_8EE3, 1'b0, 1'b1);
        run_seq("b_neg", 0);
        push(F_J, 32'h0000_04EF, 32'd26, 32'h01A0_04EF, 1'b0, 1'b1);
        run_seq("j_pos", 0);
        push(F_J, 32'h0000_04EF, -32'sd8, 32'hFF9F_F4EF, 1'b0, 1'b1);
        run_seq("j_neg", 0);

        // Range edges that are legal in both builds.
        push(F_I, 32'h0000_0093, -32'sd2048, 32'h8000_0093, 1'b0, 1'b1);
        push(F_J, 32'h0000_04EF, 32'd1048574, 32'h7FFF_F4EF, 1'b0, 1'b1);
        run_seq("edges", 0);

`ifdef IMM_ENCODER_RANGE_CHECK_EN
        push(F_B, 32'h0020_8063, 32'd5, 32'h0020_8063, 1'b1, 1'b0);
        push(F_I, 32'h0000_0093, 32'd2048, 32'h0000_0093, 1'b1, 1'b0);
        run_seq("errors", 0);
`else
        push(F_B, 32'h0020_8063, 32'd5, 32'h0020_8263, 1'b0, 1'b0);
        push(F_I, 32'h0000_0093, 32'd2048, 32'h8000_0093, 1'b0, 1'b0);
        run_seq("truncate", 0);
`endif

        // Backpressure: four back-to-back requests, consumer stalled 3 cycles.
        for (int k = 1; k <= 4; k++) begin
            push(F_I, 32'h0000_0093, k, 32'h0000_0093 | (k << 20), 1'b0, 1'b1);
        end
        run_seq("backpressure", 3);

        // Counter is at its maximum here; a full-rate burst must not wrap it.
        for (int k = 0; k < 8; k++) begin
            push(F_S, 32'h0020_A023, k, 32'h0020_A023 | (k << 7), 1'b0, 1'b1);
        end
        run_seq("saturate", 0);

        // Asynchronous reset with two words in flight.
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_control = F_I;
        in_base    = 32'h0000_0093;
        in_imm     = 32'd9;
        @(posedge clk);
        #1;
        in_imm = 32'd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("inflight out_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check_val("async rst enc_count", {28'b0, enc_count}, 32'd0);
        exp_cnt = 0;
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check_val("no stale word", stale, 32'd0);

        push(F_J, 32'h0000_04EF, 32'd26, 32'h01A0_04EF, 1'b0, 1'b1);
        run_seq("after_reset", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timed out");
    end

endmodule
